exec_cc_stage: RTL and testbench
================================

EXEC_CC_STAGE -- requirements
Module: exec_cc_stage

Interface
REQ-001 SHALL have parameter: WIDTH, 64, datapath width of the ALU result consumed.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: e_valid  input  1  execute-stage instruction valid.
REQ-005 SHALL have port: set_cc  input  1  instruction in execute is OPq; update CC this cycle.
REQ-006 SHALL have port: alu_result  input  WIDTH  signed sum/difference from alu_adder_64.
REQ-007 SHALL have port: alu_overflow  input  1  signed overflow from alu_adder_64.
REQ-008 SHALL have port: ifun  input  4  condition function of jXX/cmovXX in execute.
REQ-009 SHALL have port: stall  input  1  hold execute->memory register.
REQ-010 SHALL have port: bubble  input  1  insert NOP into memory stage.
REQ-011 SHALL have ports: zf, sf, of  output  1 each  registered condition codes.
REQ-012 SHALL have port: e_cnd  output  1  combinational condition from current CC and ifun.
REQ-013 SHALL have ports: m_valE  output  WIDTH, m_cnd  output  1, m_valid  output  1  registered memory-stage values.

Function
REQ-014 SHALL compute next flags as: ZF = (alu_result == 0), SF = alu_result[WIDTH-1], OF = alu_overflow.
REQ-015 SHALL load zf/sf/of on a rising edge only when e_valid & set_cc & ~stall; otherwise hold.
REQ-016 SHALL evaluate e_cnd from the registered flags, not the flags being computed this cycle (1-cycle CC latency).
REQ-017 SHALL decode ifun: 0 always=1; 1 le=(sf^of)|zf; 2 l=sf^of; 3 e=zf; 4 ne=~zf; 5 ge=~(sf^of); 6 g=~(sf^of)&~zf; 7-15 = 0.
REQ-018 SHALL, when ~stall & ~bubble, register m_valE=alu_result, m_cnd=e_cnd, m_valid=e_valid on the rising edge.
REQ-019 SHALL, when stall, hold m_valE/m_cnd/m_valid unchanged.
REQ-020 SHALL, when bubble & ~stall, set m_valid=0, m_cnd=0, m_valE=0.
REQ-021 SHALL give stall priority when stall and bubble are both asserted.
REQ-022 SHALL not update CC when e_valid=0, regardless of set_cc.
REQ-023 SHALL accept alu_result = 0 with alu_overflow=1 (wrap to zero) as ZF=1, OF=1.

Reset
REQ-024 SHALL, on rising edge with rst=1, set zf=1, sf=0, of=0, m_valE=0, m_cnd=0, m_valid=0.
REQ-025 SHALL give rst priority over stall, bubble and set_cc, including mid-operation.
REQ-026 SHALL have e_cnd reflect the reset flags the cycle after reset (ifun=3 gives e_cnd=1).

Configuration
REQ-027 SHALL, with EXC_CC_GUARD_EN defined, add port exc_inhibit  input  1; CC update requires additionally ~exc_inhibit (exception in memory/write-back stage blocks CC change).
REQ-028 SHALL, without EXC_CC_GUARD_EN, omit exc_inhibit, with CC update per REQ-015 alone.

Verification
REQ-029 SHALL cover: reset, then set_cc with alu_result=-610 (-456 + -154), overflow=0 -> next cycle zf=0, sf=1, of=0; ifun=2 gives e_cnd=1.
REQ-030 SHALL cover: alu_result=20356, set_cc=1 -> zf=0, sf=0; ifun=6 gives e_cnd=1; ifun=1 gives e_cnd=0.
REQ-031 SHALL cover: a=b=64'hABCDABCDABCDABCD summed, alu_result=64'h579B579B579B579A, overflow=1 -> of=1, sf=0; ifun=5 gives e_cnd=0.
REQ-032 SHALL cover: stall=1 for 3 cycles with set_cc=1, alu_result=0 -> flags and m_valE unchanged; stall=1 & bubble=1 -> hold.
REQ-033 SHALL cover: bubble=1, stall=0 -> m_valid=0, m_valE=0 next cycle; rst asserted mid-stream -> zf=1, sf=0, of=0, m_valid=0.
REQ-034 SHALL cover (EXC_CC_GUARD_EN): exc_inhibit=1, set_cc=1, alu_result=0 -> zf remains 0 after prior nonzero result.

Source files
------------

// File: rtl/exec_cc_stage.sv
// exec_cc_stage -- execute-stage condition-code register and execute->memory
// pipeline register.
//
// Condition codes (zf/sf/of) are derived from the ALU result and latched when
// a valid OPq instruction sits in execute and the stage is not stalled. The
// branch/cmov condition e_cnd is decoded from the *registered* flags, so a
// compare followed immediately by a jXX sees the flags one cycle later.
//
// Optional build macro: EXC_CC_GUARD_EN
//   When defined, adds input exc_inhibit. An exception further down the pipe
//   (memory/write-back) then blocks any condition-code update.

module exec_cc_stage #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             e_valid,
    input  logic             set_cc,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_overflow,
    input  logic [3:0]       ifun,
    input  logic             stall,
    input  logic             bubble,
`ifdef EXC_CC_GUARD_EN
    input  logic             exc_inhibit,
`endif
    output logic             zf,
    output logic             sf,
    output logic             of,
    output logic             e_cnd,
    output logic [WIDTH-1:0] m_valE,
    output logic             m_cnd,
    output logic             m_valid
);

    // Condition function encoding used by jXX / cmovXX.
    localparam logic [3:0] C_YES = 4'd0;
    localparam logic [3:0] C_LE  = 4'd1;
    localparam logic [3:0] C_L   = 4'd2;
    localparam logic [3:0] C_E   = 4'd3;
    localparam logic [3:0] C_NE  = 4'd4;
    localparam logic [3:0] C_GE  = 4'd5;
    localparam logic [3:0] C_G   = 4'd6;

    // Evaluate a condition function against a set of flags; unused codes are false.
    function automatic logic cond_eval(input logic [3:0] fn, input logic z,
                                       input logic s, input logic o);
        logic lt;
        logic res;
        lt = s ^ o;
        case (fn)
            C_YES:   res = 1'b1;
            C_LE:    res = lt | z;
            C_L:     res = lt;
            C_E:     res = z;
            C_NE:    res = ~z;
            C_GE:    res = ~lt;
            C_G:     res = ~lt & ~z;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    logic             zf_q, sf_q, of_q;
    logic             zf_d, sf_d, of_d;
    logic             cc_we_s;
    logic             e_cnd_s;
    logic [WIDTH-1:0] m_vale_q, m_vale_d;
    logic             m_cnd_q, m_cnd_d;
    logic             m_valid_q, m_valid_d;

    // CC write enable: valid OPq in execute, not stalled (and not inhibited if guarded).
`ifdef EXC_CC_GUARD_EN
    assign cc_we_s = e_valid & set_cc & ~stall & ~exc_inhibit;
`else
    assign cc_we_s = e_valid & set_cc & ~stall;
`endif

    // Next-state condition codes: load from the ALU result or hold.
    always_comb begin
        zf_d = zf_q;
        sf_d = sf_q;
        of_d = of_q;
        if (cc_we_s) begin
            zf_d = (alu_result == {WIDTH{1'b0}});
            sf_d = alu_result[WIDTH-1];
            of_d = alu_overflow;
        end else begin
            zf_d = zf_q;
            sf_d = sf_q;
            of_d = of_q;
        end
    end

    // Branch condition decoded from the already-registered flags (one-cycle CC latency).
    always_comb begin
        e_cnd_s = cond_eval(ifun, zf_q, sf_q, of_q);
    end

    // Next-state memory-stage register: stall holds, bubble inserts a NOP, else advance.
    always_comb begin
        m_vale_d  = m_vale_q;
        m_cnd_d   = m_cnd_q;
        m_valid_d = m_valid_q;
        if (stall) begin
            m_vale_d  = m_vale_q;
            m_cnd_d   = m_cnd_q;
            m_valid_d = m_valid_q;
        end else if (bubble) begin
            m_vale_d  = {WIDTH{1'b0}};
            m_cnd_d   = 1'b0;
            m_valid_d = 1'b0;
        end else begin
            m_vale_d  = alu_result;
            m_cnd_d   = e_cnd_s;
            m_valid_d = e_valid;
        end
    end

    // Condition-code register; reset leaves the "result was zero" state.
    always_ff @(posedge clk) begin
        if (rst) begin
            zf_q <= 1'b1;
            sf_q <= 1'b0;
            of_q <= 1'b0;
        end else begin
            zf_q <= zf_d;
            sf_q <= sf_d;
            of_q <= of_d;
        end
    end

    // Execute->memory pipeline register; reset has priority over stall/bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_vale_q  <= {WIDTH{1'b0}};
            m_cnd_q   <= 1'b0;
            m_valid_q <= 1'b0;
        end else begin
            m_vale_q  <= m_vale_d;
            m_cnd_q   <= m_cnd_d;
            m_valid_q <= m_valid_d;
        end
    end

    assign zf      = zf_q;
    assign sf      = sf_q;
    assign of      = of_q;
    assign e_cnd   = e_cnd_s;
    assign m_valE  = m_vale_q;
    assign m_cnd   = m_cnd_q;
    assign m_valid = m_valid_q;

endmodule

// File: tb/tb_exec_cc_stage.sv
// Testbench for exec_cc_stage: directed vectors, literal expectations and a
// cycle-by-cycle comparison against a behavioural model of the stage.

module tb_exec_cc_stage;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         e_valid;
    logic         set_cc;
    logic [W-1:0] alu_result;
    logic         alu_overflow;
    logic [3:0]   ifun;
    logic         stall;
    logic         bubble;
    logic         exc_inhibit;
    logic         zf, sf, of, e_cnd;
    logic [W-1:0] m_valE;
    logic         m_cnd, m_valid;

    int errors = 0;
    int checks = 0;

    exec_cc_stage #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .e_valid      (e_valid),
        .set_cc       (set_cc),
        .alu_result   (alu_result),
        .alu_overflow (alu_overflow),
        .ifun         (ifun),
        .stall        (stall),
        .bubble       (bubble),
`ifdef EXC_CC_GUARD_EN
        .exc_inhibit  (exc_inhibit),
`endif
        .zf           (zf),
        .sf           (sf),
        .of           (of),
        .e_cnd        (e_cnd),
        .m_valE       (m_valE),
        .m_cnd        (m_cnd),
        .m_valid      (m_valid)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit         mdl_ok = 1'b0;
    bit         mz, ms, mo;
    bit [W-1:0] mvale;
    bit         mcnd, mvalid;

    function automatic bit cond_model(input int f, input bit z, input bit s, input bit o);
        bit less;
        less = (s != o);
        if (f == 0) return 1'b1;
        if (f == 1) return less || z;
        if (f == 2) return less;
        if (f == 3) return z;
        if (f == 4) return !z;
        if (f == 5) return !less;
        if (f == 6) return !less && !z;
        return 1'b0;
    endfunction

    // Model update: applies the stage rules to the inputs present at each rising edge.
    always @(posedge clk) begin
        bit cnd_now;
        bit upd;
        cnd_now = cond_model(int'(ifun), mz, ms, mo);
        upd = e_valid && set_cc && !stall;
`ifdef EXC_CC_GUARD_EN
        upd = upd && !exc_inhibit;
`endif
        if (rst) begin
            mz = 1'b1; ms = 1'b0; mo = 1'b0;
            mvale = '0; mcnd = 1'b0; mvalid = 1'b0;
            mdl_ok = 1'b1;
        end else if (mdl_ok) begin
            if (upd) begin
                mz = (alu_result == 0);
                ms = ($signed(alu_result) < 0);
                mo = alu_overflow;
            end
            if (!stall) begin
                if (bubble) begin
                    mvale = '0; mcnd = 1'b0; mvalid = 1'b0;
                end else begin
                    mvale = alu_result; mcnd = cnd_now; mvalid = e_valid;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare process: every falling edge once the model has seen reset.
    always @(negedge clk) begin
        if (mdl_ok) begin
            chk("mdl_zf", {63'd0, zf}, {63'd0, mz});
            chk("mdl_sf", {63'd0, sf}, {63'd0, ms});
            chk("mdl_of", {63'd0, of}, {63'd0, mo});
            chk("mdl_e_cnd", {63'd0, e_cnd}, {63'd0, cond_model(int'(ifun), mz, ms, mo)});
            chk("mdl_m_valE", m_valE, mvale);
            chk("mdl_m_cnd", {63'd0, m_cnd}, {63'd0, mcnd});
            chk("mdl_m_valid", {63'd0, m_valid}, {63'd0, mvalid});
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input bit sc, input logic [W-1:0] r, input bit ov,
                         input logic [3:0] f, input bit st, input bit bb);
        e_valid = v; set_cc = sc; alu_result = r; alu_overflow = ov;
        ifun = f; stall = st; bubble = bb;
    endtask

    initial begin
        rst = 1'b1; exc_inhibit = 1'b0;
        drive(1'b0, 1'b0, 64'd0, 1'b0, 4'd3, 1'b0, 1'b0);
        cycle(); cycle();
        chk("rst_zf", {63'd0, zf}, 64'd1);
        chk("rst_sf", {63'd0, sf}, 64'd0);
        chk("rst_of", {63'd0, of}, 64'd0);
        chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
        chk("rst_m_valE", m_valE, 64'd0);
        rst = 1'b0;
        #1;
        chk("rst_e_cnd_e", {63'd0, e_cnd}, 64'd1);

        // -456 + -154 = -610
        drive(1'b1, 1'b1, -64'sd610, 1'b0, 4'd2, 1'b0, 1'b0);
        cycle();
        chk("neg_zf", {63'd0, zf}, 64'd0);
        chk("neg_sf", {63'd0, sf}, 64'd1);
        chk("neg_of", {63'd0, of}, 64'd0);
        chk("neg_e_cnd_l", {63'd0, e_cnd}, 64'd1);
        chk("neg_m_valE", m_valE, 64'hFFFF_FFFF_FFFF_FD9E);
        chk("neg_m_cnd_old_flags", {63'd0, m_cnd}, 64'd0);

        drive(1'b1, 1'b1, 64'd20356, 1'b0, 4'd6, 1'b0, 1'b0);
        cycle();
        chk("pos_zf", {63'd0, zf}, 64'd0);
        chk("pos_sf", {63'd0, sf}, 64'd0);
        chk("pos_e_cnd_g", {63'd0, e_cnd}, 64'd1);
        ifun = 4'd1; #1;
        chk("pos_e_cnd_le", {63'd0, e_cnd}, 64'd0);

        drive(1'b1, 1'b1, 64'h579B_579B_579B_579A, 1'b1, 4'd5, 1'b0, 1'b0);
        cycle();
        chk("ovf_of", {63'd0, of}, 64'd1);
        chk("ovf_sf", {63'd0, sf}, 64'd0);
        chk("ovf_e_cnd_ge", {63'd0, e_cnd}, 64'd0);

        // Stall three cycles with a zero result offered: nothing moves.
        drive(1'b1, 1'b1, 64'd0, 1'b0, 4'd0, 1'b1, 1'b0);
        cycle(); cycle(); cycle();
        chk("stall_zf", {63'd0, zf}, 64'd0);
        chk("stall_of", {63'd0, of}, 64'd1);
        chk("stall_m_valE", m_valE, 64'h579B_579B_579B_579A);
        bubble = 1'b1;
        cycle();
        chk("stall_bubble_m_valid", {63'd0, m_valid}, 64'd1);
        chk("stall_bubble_m_valE", m_valE, 64'h579B_579B_579B_579A);

        drive(1'b1, 1'b0, 64'd77, 1'b0, 4'd0, 1'b0, 1'b1);
        cycle();
        chk("bubble_m_valid", {63'd0, m_valid}, 64'd0);
        chk("bubble_m_valE", m_valE, 64'd0);

        // set_cc without a valid instruction must not touch the flags.
        drive(1'b0, 1'b1, 64'd0, 1'b0, 4'd4, 1'b0, 1'b0);
        cycle();
        chk("invalid_zf", {63'd0, zf}, 64'd0);
        chk("invalid_m_valid", {63'd0, m_valid}, 64'd0);

`ifdef EXC_CC_GUARD_EN
        exc_inhibit = 1'b1;
        drive(1'b1, 1'b1, 64'd0, 1'b0, 4'd4, 1'b0, 1'b0);
        cycle();
        chk("inhibit_zf", {63'd0, zf}, 64'd0);
        exc_inhibit = 1'b0;
`endif

        // Wrap to zero with overflow.
        drive(1'b1, 1'b1, 64'd0, 1'b1, 4'd3, 1'b0, 1'b0);
        cycle();
        chk("wrap_zf", {63'd0, zf}, 64'd1);
        chk("wrap_of", {63'd0, of}, 64'd1);
        chk("wrap_e_cnd_e", {63'd0, e_cnd}, 64'd1);

        // Sweep every condition function against the current flags (z=1,s=0,o=1).
        for (int f = 0; f < 16; f++) begin
            drive(1'b1, 1'b0, 64'(f), 1'b0, 4'(f), 1'b0, 1'b0);
            cycle();
        end
        ifun = 4'd9; #1;
        chk("ifun9_e_cnd", {63'd0, e_cnd}, 64'd0);
        ifun = 4'd1; #1;
        chk("ifun1_le_e_cnd", {63'd0, e_cnd}, 64'd1);

        drive(1'b1, 1'b1, 64'h8000_0000_0000_0000, 1'b0, 4'd2, 1'b0, 1'b0);
        cycle();
        chk("min_sf", {63'd0, sf}, 64'd1);

        // Reset mid-stream with everything else asserted.
        rst = 1'b1;
        drive(1'b1, 1'b1, 64'h1234, 1'b1, 4'd3, 1'b1, 1'b1);
        cycle();
        rst = 1'b0;
        drive(1'b0, 1'b0, 64'd0, 1'b0, 4'd3, 1'b1, 1'b0);
        #1;
        chk("midrst_zf", {63'd0, zf}, 64'd1);
        chk("midrst_sf", {63'd0, sf}, 64'd0);
        chk("midrst_of", {63'd0, of}, 64'd0);
        chk("midrst_m_valid", {63'd0, m_valid}, 64'd0);
        chk("midrst_e_cnd", {63'd0, e_cnd}, 64'd1);
        cycle();
        @(negedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
